conv_layer_sequencer: RTL and testbench
=======================================

Name: conv_layer_sequencer

Overview:
Layer-level controller in front of the INT8 conv2d core. It accepts one layer descriptor over a valid/ready handshake and programs the core's configuration registers through the cfg write port. It then issues one start pulse per tile, waits for the core's done pulse after each, and reports layer completion. It sits between the host/command queue and the conv core; it never touches the activation/weight data stream.

Parameters:
CFG_BASE, 6'h10, cfg_addr of first config register; the five registers occupy CFG_BASE..CFG_BASE+4.
TILE_W, 16, width of tile count and tile index.
WDOG_CYCLES, 65535, watchdog limit in cycles per tile (used only with the optional feature).

Ports:
clk  in  1  clock
rst_b  in  1  reset (async, active-low)
desc_valid  in  1  layer descriptor valid
desc_ready  out  1  sequencer can accept descriptor
desc_ifm_h  in  16  input feature map height
desc_ifm_w  in  16  input feature map width
desc_ofm_c  in  16  output channels
desc_ksize  in  8  kernel size
desc_stride  in  8  stride
desc_tiles  in  TILE_W  number of tiles in layer
abort  in  1  synchronous abort request
cfg_wr_en  out  1  config write strobe to core
cfg_addr  out  6  config register address
cfg_wdata  out  64  config write data
core_start  out  1  one-cycle start pulse to core
core_done  in  1  one-cycle done pulse from core
tile_idx  out  TILE_W  index of tile currently running
seq_busy  out  1  layer in progress
layer_done  out  1  one-cycle pulse, layer finished
aborted  out  1  one-cycle pulse, layer aborted
err_timeout  out  1  sticky watchdog error (tied 0 without the feature)

Behaviour:
- Reset: rst_b is asynchronous, active-low; clock is clk. All outputs are registered.
- Reset values: cfg_wr_en=0, cfg_addr=0, cfg_wdata=0, core_start=0, tile_idx=0, seq_busy=0, layer_done=0, aborted=0, err_timeout=0. State returns to IDLE.
- desc_ready = (state==IDLE); it is the only combinational output.
- States:
  - IDLE: on desc_valid&&desc_ready, latch all descriptor fields and go to CFG. Tiles==0 is latched as 1. Clear tile_idx and err_timeout.
  - CFG: five consecutive cycles, with cfg_wr_en high in each.
    - cfg_addr = CFG_BASE+k for k=0..4.
    - cfg_wdata, zero-extended, is ifm_h, ifm_w, ofm_c, ksize, stride in that order.
    - After k=4, go to START.
  - START: core_start high for exactly one cycle, then WAIT.
  - WAIT: on core_done:
    - If tile_idx==tiles-1, go to DONE.
    - Else tile_idx++ and go to START.
  - DONE: layer_done high for one cycle, then IDLE.
- Latency: with descriptor accepted at edge 0:
  - Cfg writes occupy cycles 1-5; core_start is high in cycle 6.
  - Done sampled at edge n puts core_start high in cycle n+1 for the next tile, or layer_done high in cycle n+1 for the last tile.
- seq_busy is high in every state except IDLE.
- Config is written once per layer, not per tile.
- core_done outside WAIT is ignored.
- abort: in any non-IDLE state, abort sampled high causes the following:
  - Next cycle: state=IDLE, aborted pulses for 1 cycle, layer_done does not pulse.
  - cfg_wr_en and core_start are forced low from the next cycle.
  - tile_idx holds its value.
  - In IDLE, abort is ignored.
  - abort has priority over core_done in the same cycle.
- A new descriptor is accepted no earlier than the cycle after layer_done or aborted, i.e. when IDLE is re-entered.
- Descriptor inputs need only be stable in the accept cycle.

Optional Feature:
Macro CONV_SEQ_WDOG_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches WDOG_CYCLES without core_done, the sequencer sets err_timeout (sticky until next descriptor accept), pulses aborted, and returns to IDLE.
  - core_done in the same cycle as expiry wins: no timeout.
- Not defined: no counter is present, err_timeout is constant 0, and WAIT lasts indefinitely.

Test Plan:
- Descriptor h=32,w=32,c=16,k=3,s=1,tiles=1; core_done 10 cycles after start -> writes (0x10,32),(0x11,32),(0x12,16),(0x13,3),(0x14,1) in cycles 1-5; core_start cycle 6; layer_done exactly 1 cycle after done; desc_ready high again after.
- tiles=4, done returned 5 cycles after each start -> exactly 4 core_start pulses, tile_idx 0,1,2,3, config written only once, single layer_done.
- tiles=0 -> treated as 1: one start, one layer_done.
- Spurious core_done during CFG, then abort asserted in WAIT of tile 2 of 3 -> spurious done ignored; aborted pulses next cycle; no layer_done; tile_idx=1 held; next descriptor accepted.
- rst_b low mid-CFG (cycle 3) -> cfg_wr_en drops asynchronously, all outputs at reset values, no core_start; after release a fresh descriptor runs normally.
- CONV_SEQ_WDOG_EN with WDOG_CYCLES=8 and no core_done -> err_timeout=1 and aborted pulse after 8 WAIT cycles; err_timeout clears on next accept. Done on cycle 8 exactly -> no error.

Source files
------------

// File: rtl/conv_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : conv_layer_sequencer
// Purpose  : Accepts a layer descriptor, programs the conv core config
//            registers once, then runs one start/done handshake per tile.
//            Optional watchdog per tile: define CONV_SEQ_WDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module conv_layer_sequencer #(
    parameter logic [5:0] CFG_BASE    = 6'h10,
    parameter int         TILE_W      = 16,
    parameter int         WDOG_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              desc_valid,
    output logic              desc_ready,
    input  logic [15:0]       desc_ifm_h,
    input  logic [15:0]       desc_ifm_w,
    input  logic [15:0]       desc_ofm_c,
    input  logic [7:0]        desc_ksize,
    input  logic [7:0]        desc_stride,
    input  logic [TILE_W-1:0] desc_tiles,
    input  logic              abort,
    output logic              cfg_wr_en,
    output logic [5:0]        cfg_addr,
    output logic [63:0]       cfg_wdata,
    output logic              core_start,
    input  logic              core_done,
    output logic [TILE_W-1:0] tile_idx,
    output logic              seq_busy,
    output logic              layer_done,
    output logic              aborted,
    output logic              err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CFG   = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    logic [2:0]        r_cfg_idx;
    logic [15:0]       r_ifm_h;
    logic [15:0]       r_ifm_w;
    logic [15:0]       r_ofm_c;
    logic [7:0]        r_ksize;
    logic [7:0]        r_stride;
    logic [TILE_W-1:0] r_tiles;
    logic [TILE_W-1:0] r_tile_idx;
    logic              r_cfg_wr_en;
    logic [5:0]        r_cfg_addr;
    logic [63:0]       r_cfg_wdata;
    logic              r_core_start;
    logic              r_seq_busy;
    logic              r_layer_done;
    logic              r_aborted;

    logic [2:0]        w_cfg_next_idx;
    logic [63:0]       w_cfg_next_data;
    logic              w_last_tile;

`ifdef CONV_SEQ_WDOG_EN
    localparam int                WDOG_W      = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] C_WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] r_wdog_cnt;
    logic              r_err_timeout;

    assign err_timeout = r_err_timeout;
`else
    assign err_timeout = 1'b0;
`endif

    assign desc_ready = (r_state == S_IDLE);
    assign cfg_wr_en  = r_cfg_wr_en;
    assign cfg_addr   = r_cfg_addr;
    assign cfg_wdata  = r_cfg_wdata;
    assign core_start = r_core_start;
    assign tile_idx   = r_tile_idx;
    assign seq_busy   = r_seq_busy;
    assign layer_done = r_layer_done;
    assign aborted    = r_aborted;

    assign w_last_tile = (r_tile_idx == (r_tiles - TILE_W'(1)));

    // Register 0 is written straight from the descriptor on accept; the
    // remaining four come from the latched copy.
    always_comb begin
        w_cfg_next_idx  = r_cfg_idx + 3'd1;
        w_cfg_next_data = 64'd0;
        case (w_cfg_next_idx)
            3'd1:    w_cfg_next_data = {48'd0, r_ifm_w};
            3'd2:    w_cfg_next_data = {48'd0, r_ofm_c};
            3'd3:    w_cfg_next_data = {56'd0, r_ksize};
            3'd4:    w_cfg_next_data = {56'd0, r_stride};
            default: w_cfg_next_data = {48'd0, r_ifm_h};
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state       <= S_IDLE;
            r_cfg_idx     <= 3'd0;
            r_ifm_h       <= 16'd0;
            r_ifm_w       <= 16'd0;
            r_ofm_c       <= 16'd0;
            r_ksize       <= 8'd0;
            r_stride      <= 8'd0;
            r_tiles       <= '0;
            r_tile_idx    <= '0;
            r_cfg_wr_en   <= 1'b0;
            r_cfg_addr    <= 6'd0;
            r_cfg_wdata   <= 64'd0;
            r_core_start  <= 1'b0;
            r_seq_busy    <= 1'b0;
            r_layer_done  <= 1'b0;
            r_aborted     <= 1'b0;
`ifdef CONV_SEQ_WDOG_EN
            r_wdog_cnt    <= '0;
            r_err_timeout <= 1'b0;
`endif
        end else begin
            r_cfg_wr_en  <= 1'b0;
            r_core_start <= 1'b0;
            r_layer_done <= 1'b0;
            r_aborted    <= 1'b0;

            // Abort outranks every other event, including a same-cycle done.
            if ((r_state != S_IDLE) && abort) begin
                r_state    <= S_IDLE;
                r_seq_busy <= 1'b0;
                r_aborted  <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (desc_valid) begin
                            r_ifm_h       <= desc_ifm_h;
                            r_ifm_w       <= desc_ifm_w;
                            r_ofm_c       <= desc_ofm_c;
                            r_ksize       <= desc_ksize;
                            r_stride      <= desc_stride;
                            r_tiles       <= (desc_tiles == '0) ? TILE_W'(1) : desc_tiles;
                            r_tile_idx    <= '0;
                            r_cfg_idx     <= 3'd0;
                            r_cfg_wr_en   <= 1'b1;
                            r_cfg_addr    <= CFG_BASE;
                            r_cfg_wdata   <= {48'd0, desc_ifm_h};
                            r_seq_busy    <= 1'b1;
                            r_state       <= S_CFG;
`ifdef CONV_SEQ_WDOG_EN
                            r_err_timeout <= 1'b0;
`endif
                        end
                    end
                    S_CFG: begin
                        if (r_cfg_idx == 3'd4) begin
                            r_core_start <= 1'b1;
                            r_state      <= S_START;
                        end else begin
                            r_cfg_idx   <= w_cfg_next_idx;
                            r_cfg_wr_en <= 1'b1;
                            r_cfg_addr  <= CFG_BASE + {3'd0, w_cfg_next_idx};
                            r_cfg_wdata <= w_cfg_next_data;
                        end
                    end
                    S_START: begin
                        r_state <= S_WAIT;
`ifdef CONV_SEQ_WDOG_EN
                        r_wdog_cnt <= '0;
`endif
                    end
                    S_WAIT: begin
                        if (core_done) begin
                            if (w_last_tile) begin
                                r_layer_done <= 1'b1;
                                r_state      <= S_DONE;
                            end else begin
                                r_tile_idx   <= r_tile_idx + TILE_W'(1);
                                r_core_start <= 1'b1;
                                r_state      <= S_START;
                            end
                        end
`ifdef CONV_SEQ_WDOG_EN
                        else if (r_wdog_cnt == C_WDOG_LAST) begin
                            r_err_timeout <= 1'b1;
                            r_aborted     <= 1'b1;
                            r_seq_busy    <= 1'b0;
                            r_state       <= S_IDLE;
                        end else begin
                            r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
                        end
`endif
                    end
                    S_DONE: begin
                        r_seq_busy <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                    default: begin
                        r_seq_busy <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_layer_sequencer
// Purpose  : Randomized scenarios for conv_layer_sequencer checked against an
//            event-timeline model derived from descriptor fields and core delay.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_layer_sequencer;

    localparam int         TILE_W   = 16;
    localparam logic [5:0] CFG_BASE = 6'h10;
`ifdef CONV_SEQ_WDOG_EN
    localparam int TB_WDOG  = 8;
    localparam int SINGLE_D = 7;
`else
    localparam int TB_WDOG  = 65535;
    localparam int SINGLE_D = 10;
`endif

    logic              clk;
    logic              rst_b;
    logic              desc_valid;
    logic              desc_ready;
    logic [15:0]       desc_ifm_h;
    logic [15:0]       desc_ifm_w;
    logic [15:0]       desc_ofm_c;
    logic [7:0]        desc_ksize;
    logic [7:0]        desc_stride;
    logic [TILE_W-1:0] desc_tiles;
    logic              abort;
    logic              cfg_wr_en;
    logic [5:0]        cfg_addr;
    logic [63:0]       cfg_wdata;
    logic              core_start;
    logic              core_done;
    logic [TILE_W-1:0] tile_idx;
    logic              seq_busy;
    logic              layer_done;
    logic              aborted;
    logic              err_timeout;

    conv_layer_sequencer #(
        .CFG_BASE    (CFG_BASE),
        .TILE_W      (TILE_W),
        .WDOG_CYCLES (TB_WDOG)
    ) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .desc_valid  (desc_valid),
        .desc_ready  (desc_ready),
        .desc_ifm_h  (desc_ifm_h),
        .desc_ifm_w  (desc_ifm_w),
        .desc_ofm_c  (desc_ofm_c),
        .desc_ksize  (desc_ksize),
        .desc_stride (desc_stride),
        .desc_tiles  (desc_tiles),
        .abort       (abort),
        .cfg_wr_en   (cfg_wr_en),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .core_start  (core_start),
        .core_done   (core_done),
        .tile_idx    (tile_idx),
        .seq_busy    (seq_busy),
        .layer_done  (layer_done),
        .aborted     (aborted),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc, done_at, abort_cyc, spur_cyc, resp_delay;
    int          cfg_cyc_q[$];
    logic [5:0]  cfg_addr_q[$];
    logic [63:0] cfg_data_q[$];
    int          start_cyc_q[$];
    int          start_tile_q[$];
    int          ldone_q[$];
    int          abort_q[$];

    // One clock: cycle n is the window after edge n-1; the core model answers
    // resp_delay cycles after each start it sees.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        core_done = (cyc == done_at) || (cyc == spur_cyc);
        abort     = (cyc == abort_cyc);
        if (cfg_wr_en) begin
            cfg_cyc_q.push_back(cyc);
            cfg_addr_q.push_back(cfg_addr);
            cfg_data_q.push_back(cfg_wdata);
        end
        if (core_start) begin
            start_cyc_q.push_back(cyc);
            start_tile_q.push_back(int'(tile_idx));
            if (resp_delay >= 0) done_at = cyc + resp_delay;
        end
        if (layer_done) ldone_q.push_back(cyc);
        if (aborted)    abort_q.push_back(cyc);
    endtask

    task automatic randomize_desc_inputs();
        desc_ifm_h  = 16'($urandom);
        desc_ifm_w  = 16'($urandom);
        desc_ofm_c  = 16'($urandom);
        desc_ksize  = 8'($urandom);
        desc_stride = 8'($urandom);
        desc_tiles  = TILE_W'($urandom);
    endtask

    task automatic send_desc(input logic [15:0] h, input logic [15:0] w, input logic [15:0] c,
                             input logic [7:0] k, input logic [7:0] s, input logic [TILE_W-1:0] t);
        int n;
        cfg_cyc_q.delete(); cfg_addr_q.delete(); cfg_data_q.delete();
        start_cyc_q.delete(); start_tile_q.delete(); ldone_q.delete(); abort_q.delete();
        done_at = -1000; abort_cyc = -1000; spur_cyc = -1000;
        n = 0;
        while (!desc_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (n >= 50) $display("FAIL desc_ready_wait: desc_ready=%0b after %0d cycles, required 1", desc_ready, n);
        else n_pass++;
        desc_ifm_h = h; desc_ifm_w = w; desc_ofm_c = c;
        desc_ksize = k; desc_stride = s; desc_tiles = t;
        desc_valid = 1'b1;
        cyc = 0;
        step();
        desc_valid = 1'b0;
        randomize_desc_inputs();
    endtask

    // Full layer; expected timeline: writes in cycles 1-5, start i in cycle
    // 6+i*(d+1), done d cycles later, layer_done the cycle after the last done.
    task automatic test_layer(input logic [15:0] h, input logic [15:0] w, input logic [15:0] c,
                              input logic [7:0] k, input logic [7:0] s,
                              input logic [TILE_W-1:0] t, input int d);
        int nt, exp_ldone;
        logic [63:0] exp_data [5];
        nt = (t == '0) ? 1 : int'(t);
        exp_data[0] = 64'(h); exp_data[1] = 64'(w); exp_data[2] = 64'(c);
        exp_data[3] = 64'(k); exp_data[4] = 64'(s);
        exp_ldone = 6 + nt * (d + 1);
        resp_delay = d;
        send_desc(h, w, c, k, s, t);
        n_checks++;
        if (err_timeout !== 1'b0) $display("FAIL err_clear_on_accept: err_timeout=%0b, required 0", err_timeout);
        else n_pass++;
        while (cyc < exp_ldone + 1) begin
            step();
            if (cyc == exp_ldone) begin
                n_checks++;
                if (seq_busy !== 1'b1 || desc_ready !== 1'b0)
                    $display("FAIL busy_in_done: seq_busy=%0b desc_ready=%0b, required 1/0", seq_busy, desc_ready);
                else n_pass++;
            end
        end
        n_checks++;
        if (cfg_cyc_q.size() != 5) $display("FAIL cfg_count: got %0d writes, required 5", cfg_cyc_q.size());
        else n_pass++;
        for (int i = 0; i < 5 && i < cfg_cyc_q.size(); i++) begin
            n_checks++;
            if (cfg_cyc_q[i] != i + 1 || cfg_addr_q[i] !== CFG_BASE + 6'(i) || cfg_data_q[i] !== exp_data[i])
                $display("FAIL cfg_write[%0d]: cyc=%0d addr=%h data=%h, required cyc=%0d addr=%h data=%h",
                         i, cfg_cyc_q[i], cfg_addr_q[i], cfg_data_q[i], i + 1, CFG_BASE + 6'(i), exp_data[i]);
            else n_pass++;
        end
        n_checks++;
        if (start_cyc_q.size() != nt) $display("FAIL start_count: got %0d, required %0d", start_cyc_q.size(), nt);
        else n_pass++;
        for (int i = 0; i < nt && i < start_cyc_q.size(); i++) begin
            n_checks++;
            if (start_cyc_q[i] != 6 + i * (d + 1) || start_tile_q[i] != i)
                $display("FAIL start[%0d]: cyc=%0d tile=%0d, required cyc=%0d tile=%0d",
                         i, start_cyc_q[i], start_tile_q[i], 6 + i * (d + 1), i);
            else n_pass++;
        end
        n_checks++;
        if (ldone_q.size() != 1 || ldone_q[0] != exp_ldone)
            $display("FAIL layer_done: count=%0d first=%0d, required count=1 cyc=%0d",
                     ldone_q.size(), (ldone_q.size() > 0) ? ldone_q[0] : -1, exp_ldone);
        else n_pass++;
        n_checks++;
        if (abort_q.size() != 0 || err_timeout !== 1'b0)
            $display("FAIL no_abort: aborted count=%0d err_timeout=%0b, required 0/0", abort_q.size(), err_timeout);
        else n_pass++;
        n_checks++;
        if (desc_ready !== 1'b1 || seq_busy !== 1'b0)
            $display("FAIL idle_after_layer: desc_ready=%0b seq_busy=%0b, required 1/0", desc_ready, seq_busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_b = 1'b0; desc_valid = 1'b0; abort = 1'b0; core_done = 1'b0;
        randomize_desc_inputs();
        cyc = 0; done_at = -1000; abort_cyc = -1000; spur_cyc = -1000; resp_delay = -1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({cfg_wr_en, cfg_addr, cfg_wdata, core_start, tile_idx, seq_busy, layer_done, aborted, err_timeout} !== '0)
            $display("FAIL reset_values: wr=%0b addr=%h data=%h start=%0b tile=%0d busy=%0b ld=%0b ab=%0b err=%0b, required all 0",
                     cfg_wr_en, cfg_addr, cfg_wdata, core_start, tile_idx, seq_busy, layer_done, aborted, err_timeout);
        else n_pass++;
        n_checks++;
        if (desc_ready !== 1'b1) $display("FAIL reset_ready: desc_ready=%0b, required 1", desc_ready);
        else n_pass++;
        rst_b = 1'b1;
        repeat (2) step();
        n_checks++;
        if (seq_busy !== 1'b0 || cfg_wr_en !== 1'b0 || desc_ready !== 1'b1)
            $display("FAIL post_reset_idle: busy=%0b wr=%0b ready=%0b, required 0/0/1", seq_busy, cfg_wr_en, desc_ready);
        else n_pass++;
    endtask

    task automatic test_abort();
        resp_delay = 6;
        send_desc(16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), TILE_W'(3));
        spur_cyc  = 3;
        abort_cyc = 16;
        while (cyc < 24) begin
            step();
            if (cyc == 17) begin
                n_checks++;
                if (aborted !== 1'b1 || tile_idx !== TILE_W'(1) || seq_busy !== 1'b0 || desc_ready !== 1'b1 ||
                    cfg_wr_en !== 1'b0 || core_start !== 1'b0 || layer_done !== 1'b0)
                    $display("FAIL abort_cycle: ab=%0b tile=%0d busy=%0b ready=%0b wr=%0b start=%0b ld=%0b, required 1/1/0/1/0/0/0",
                             aborted, tile_idx, seq_busy, desc_ready, cfg_wr_en, core_start, layer_done);
                else n_pass++;
            end
            if (cyc == 21) abort_cyc = 22;
        end
        n_checks++;
        if (start_cyc_q.size() != 2 || start_cyc_q[0] != 6 || start_cyc_q[1] != 13)
            $display("FAIL abort_starts: count=%0d, required 2 starts at cycles 6,13", start_cyc_q.size());
        else n_pass++;
        n_checks++;
        if (abort_q.size() != 1 || ldone_q.size() != 0 || tile_idx !== TILE_W'(1))
            $display("FAIL abort_events: aborted=%0d layer_done=%0d tile=%0d, required 1/0/1",
                     abort_q.size(), ldone_q.size(), tile_idx);
        else n_pass++;
    endtask

    task automatic test_abort_priority();
        resp_delay = 4;
        send_desc(16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), TILE_W'(2));
        abort_cyc = 10;
        while (cyc < 14) step();
        n_checks++;
        if (abort_q.size() != 1 || abort_q[0] != 11 || start_cyc_q.size() != 1 || ldone_q.size() != 0 || tile_idx !== '0)
            $display("FAIL abort_over_done: aborted=%0d starts=%0d ld=%0d tile=%0d, required aborted@11 starts=1 ld=0 tile=0",
                     abort_q.size(), start_cyc_q.size(), ldone_q.size(), tile_idx);
        else n_pass++;
    endtask

    task automatic test_reset_mid_cfg();
        resp_delay = 3;
        send_desc(16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), TILE_W'(2));
        while (cyc < 3) step();
        #2;
        rst_b = 1'b0;
        #1;
        n_checks++;
        if ({cfg_wr_en, cfg_addr, cfg_wdata, core_start, tile_idx, seq_busy, layer_done, aborted, err_timeout} !== '0 ||
            desc_ready !== 1'b1)
            $display("FAIL async_reset: wr=%0b addr=%h data=%h start=%0b busy=%0b ready=%0b, required reset values",
                     cfg_wr_en, cfg_addr, cfg_wdata, core_start, seq_busy, desc_ready);
        else n_pass++;
        repeat (3) step();
        rst_b = 1'b1;
        repeat (8) step();
        n_checks++;
        if (start_cyc_q.size() != 0 || cfg_cyc_q.size() != 3)
            $display("FAIL reset_stops_layer: starts=%0d writes=%0d, required 0/3", start_cyc_q.size(), cfg_cyc_q.size());
        else n_pass++;
        test_layer(16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
                   TILE_W'($urandom_range(1, 3)), $urandom_range(1, 6));
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            test_layer(16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
                       TILE_W'($urandom_range(1, 5)), $urandom_range(1, 6));
    endtask

`ifdef CONV_SEQ_WDOG_EN
    task automatic test_watchdog();
        resp_delay = -1;
        send_desc(16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), TILE_W'(1));
        while (cyc < 16) begin
            step();
            if (cyc == 14) begin
                n_checks++;
                if (err_timeout !== 1'b0 || aborted !== 1'b0 || seq_busy !== 1'b1)
                    $display("FAIL wdog_early: err=%0b ab=%0b busy=%0b in WAIT cycle 8, required 0/0/1",
                             err_timeout, aborted, seq_busy);
                else n_pass++;
            end
            if (cyc == 15) begin
                n_checks++;
                if (err_timeout !== 1'b1 || aborted !== 1'b1 || desc_ready !== 1'b1)
                    $display("FAIL wdog_expire: err=%0b ab=%0b ready=%0b, required 1/1/1", err_timeout, aborted, desc_ready);
                else n_pass++;
            end
        end
        n_checks++;
        if (err_timeout !== 1'b1 || abort_q.size() != 1 || ldone_q.size() != 0)
            $display("FAIL wdog_sticky: err=%0b aborted=%0d ld=%0d, required 1/1/0", err_timeout, abort_q.size(), ldone_q.size());
        else n_pass++;
        // Done arriving in the last allowed WAIT cycle must win.
        test_layer(16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), TILE_W'(1), TB_WDOG);
    endtask
`else
    task automatic test_no_watchdog();
        resp_delay = -1;
        send_desc(16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), TILE_W'(1));
        abort_cyc = 40;
        while (cyc < 42) begin
            step();
            if (cyc == 30) begin
                n_checks++;
                if (seq_busy !== 1'b1 || err_timeout !== 1'b0 || aborted !== 1'b0)
                    $display("FAIL wait_forever: busy=%0b err=%0b ab=%0b, required 1/0/0", seq_busy, err_timeout, aborted);
                else n_pass++;
            end
        end
        n_checks++;
        if (abort_q.size() != 1 || abort_q[0] != 41 || ldone_q.size() != 0)
            $display("FAIL wait_abort_exit: aborted=%0d ld=%0d, required one abort at 41, no layer_done",
                     abort_q.size(), ldone_q.size());
        else n_pass++;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end

    initial begin
        test_reset();
        test_layer(16'd32, 16'd32, 16'd16, 8'd3, 8'd1, TILE_W'(1), SINGLE_D);
        test_layer(16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), TILE_W'(4), 5);
        test_layer(16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), TILE_W'(0), 3);
        test_abort();
        test_layer(16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), TILE_W'(2), 2);
        test_abort_priority();
        test_reset_mid_cfg();
        test_back_to_back();
`ifdef CONV_SEQ_WDOG_EN
        test_watchdog();
`else
        test_no_watchdog();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
